vga_timing_gen: RTL and testbench

Source end of the pixel pipeline. Generates the raster stream (`hcount`/`vcount`, sync and blanking) that overlay stages such as the ball and paddle drawers consume and forward. Default mode is 1024x768 @ 60 Hz from a 65 MHz `pclk`. Also provides:
- a once-per-frame strobe and frame counter, so game objects step per frame instead of per clock;
- an optional colour-bar background.

---
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 tb/tb_vga_timing_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing source: h/v counters, sync, blanking, frame strobe.
// Optional colour bars when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic        pclk,
    input  logic        reset_n,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        frame_tick,
    output logic [15:0] frame_cnt,
    output logic [11:0] rgb_out
);

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        hsync_q, hsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vsync_q, vsync_d;
    logic        vblnk_q, vblnk_d;
    logic        tick_q, tick_d;
    logic [15:0] fcnt_q, fcnt_d;

    // Next raster position and the flags that describe it.
    always_comb begin
        h_d = h_q + 11'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = 11'd0;
            v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
        end
        hblnk_d = (h_d >= H_ACT);
        hsync_d = (h_d >= HS_BEG && h_d <= HS_END) ? SYNC_ACT : ~SYNC_ACT;
        vblnk_d = (v_d >= V_ACT);
        vsync_d = (v_d >= VS_BEG && v_d <= VS_END) ? SYNC_ACT : ~SYNC_ACT;
        tick_d  = (h_d == 11'd0) && (v_d == V_ACT);
        fcnt_d  = fcnt_q + {15'd0, tick_d};
    end

    // Counters and flags all update on the same edge.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            h_q     <= 11'd0;
            v_q     <= 11'd0;
            hsync_q <= ~SYNC_ACT;
            hblnk_q <= 1'b0;
            vsync_q <= ~SYNC_ACT;
            vblnk_q <= 1'b0;
            tick_q  <= 1'b0;
            fcnt_q  <= 16'd0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            hblnk_q <= hblnk_d;
            vsync_q <= vsync_d;
            vblnk_q <= vblnk_d;
            tick_q  <= tick_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign hcount_out = h_q;
    assign vcount_out = v_q;
    assign hsync_out  = hsync_q;
    assign hblnk_out  = hblnk_q;
    assign vsync_out  = vsync_q;
    assign vblnk_out  = vblnk_q;
    assign frame_tick = tick_q;
    assign frame_cnt  = fcnt_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    logic [10:0] bar_idx;
    logic [11:0] rgb_q, rgb_d;

    // Colour of the bar under the next pixel, black while blanked.
    always_comb begin
        bar_idx = h_d / BAR_W;
        rgb_d   = 12'h000;
        if (!hblnk_d && !vblnk_d) begin
            case (bar_idx)
                11'd0:   rgb_d = 12'hfff;
                11'd1:   rgb_d = 12'hff0;
                11'd2:   rgb_d = 12'h0ff;
                11'd3:   rgb_d = 12'h0f0;
                11'd4:   rgb_d = 12'hf0f;
                11'd5:   rgb_d = 12'hf00;
                11'd6:   rgb_d = 12'h00f;
                default: rgb_d = 12'h000;
            endcase
        end
    end

    // Pattern register, aligned with hcount_out.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb_out = rgb_q;
`else
    assign rgb_out = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line checks,
// shrunken instance for whole-frame and strobe checks.
module tb_vga_timing_gen;

    logic pclk = 1'b0;
    logic reset_n = 1'b0;

    always #5 pclk = ~pclk;

    logic [10:0] d_h, d_v;
    logic        d_hs, d_hb, d_vs, d_vb, d_tick;
    logic [15:0] d_fc;
    logic [11:0] d_rgb;

    logic [10:0] s_h, s_v;
    logic        s_hs, s_hb, s_vs, s_vb, s_tick;
    logic [15:0] s_fc;
    logic [11:0] s_rgb;

    vga_timing_gen u_dflt (
        .pclk       (pclk),
        .reset_n    (reset_n),
        .hcount_out (d_h),
        .hsync_out  (d_hs),
        .hblnk_out  (d_hb),
        .vcount_out (d_v),
        .vsync_out  (d_vs),
        .vblnk_out  (d_vb),
        .frame_tick (d_tick),
        .frame_cnt  (d_fc),
        .rgb_out    (d_rgb)
    );

    // 24 x 13 raster: frame = 312 cycles
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .pclk       (pclk),
        .reset_n    (reset_n),
        .hcount_out (s_h),
        .hsync_out  (s_hs),
        .hblnk_out  (s_hb),
        .vcount_out (s_v),
        .vsync_out  (s_vs),
        .vblnk_out  (s_vb),
        .frame_tick (s_tick),
        .frame_cnt  (s_fc),
        .rgb_out    (s_rgb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_h"},     32'(d_h), 0);
        chk({tag, "_v"},     32'(d_v), 0);
        chk({tag, "_hs"},    32'(d_hs), 1);
        chk({tag, "_vs"},    32'(d_vs), 1);
        chk({tag, "_hb"},    32'(d_hb), 0);
        chk({tag, "_vb"},    32'(d_vb), 0);
        chk({tag, "_tick"},  32'(d_tick), 0);
        chk({tag, "_fc"},    32'(d_fc), 0);
        chk({tag, "_rgb"},   32'(d_rgb), 0);
        chk({tag, "_s_fc"},  32'(s_fc), 0);
        chk({tag, "_s_h"},   32'(s_h), 0);
    endtask

    function automatic logic [11:0] bar(input logic [11:0] c);
`ifdef VGA_TEST_PATTERN_EN
        return c;
`else
        return 12'h000;
`endif
    endfunction

    initial begin
        int hs_low;
        int hs_first;
        int hs_last;
        int hb_rise;
        int vb_cnt;
        int vs_cnt;
        int ticks;
        int last_tick;
        bit wrap_pend;

        // Reset held from time zero, then release.
        step(3);
        chk_reset_vals("rst0");
        @(negedge pclk);
        reset_n = 1'b1;
        step(1);
        chk("rel0_h", 32'(d_h), 1);
        chk("rel0_v", 32'(d_v), 0);

        // Mid-line (and mid-frame for the small raster) reset.
        step(150);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        step(4);
        chk_reset_vals("rst_hold");
        @(negedge pclk);
        reset_n = 1'b1;
        step(1);
        chk("rel_h", 32'(d_h), 1);
        chk("rel_v", 32'(d_v), 0);
        chk("rel_rgb", 32'(d_rgb), 32'(bar(12'hfff)));

        // Walk line 0 from h=1 to h=1343.
        hs_low = 0;
        hs_first = -1;
        hs_last = -1;
        hb_rise = -1;
        for (int c = 1; c <= 1343; c++) begin
            if (d_hs == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(d_h);
                hs_last = int'(d_h);
            end
            if (d_hb && hb_rise < 0) hb_rise = int'(d_h);
            if (d_h == 11'd128)
                chk("rgb_128", 32'(d_rgb), 32'(bar(12'hff0)));
            if (d_h == 11'd700)
                chk("rgb_700", 32'(d_rgb), 32'(bar(12'hf00)));
            if (d_h == 11'd1024)
                chk("rgb_1024", 32'(d_rgb), 0);
            if (c < 1343) step(1);
        end
        chk("l0_h_end", 32'(d_h), 1343);
        chk("l0_hb_end", 32'(d_hb), 1);
        chk("hb_rise", 32'(hb_rise), 1024);
        chk("hs_first", 32'(hs_first), 1048);
        chk("hs_last", 32'(hs_last), 1183);
        chk("hs_low", 32'(hs_low), 136);
        step(1);
        chk("wrap1_h", 32'(d_h), 0);
        chk("wrap1_v", 32'(d_v), 1);
        chk("wrap1_hb", 32'(d_hb), 0);
        chk("rgb_0", 32'(d_rgb), 32'(bar(12'hfff)));

        // Advance to (1343,5) and wrap to (0,6).
        step(4 * 1344 + 1343);
        chk("l5_h", 32'(d_h), 1343);
        chk("l5_v", 32'(d_v), 5);
        step(1);
        chk("l6_h", 32'(d_h), 0);
        chk("l6_v", 32'(d_v), 6);
        chk("l6_vb", 32'(d_vb), 0);

        // Fresh start for the small raster's frame checks.
        #3;
        reset_n = 1'b0;
        step(2);
        @(negedge pclk);
        reset_n = 1'b1;
        step(1);
        chk("s_rel_h", 32'(s_h), 1);
        chk("s_rel_fc", 32'(s_fc), 0);

        vb_cnt = 0;
        vs_cnt = 0;
        ticks = 0;
        last_tick = -1;
        wrap_pend = 1'b0;
        for (int c = 1; c <= 900; c++) begin
            if (wrap_pend) begin
                chk("s_wrap_h", 32'(s_h), 0);
                chk("s_wrap_v", 32'(s_v), 0);
                chk("s_wrap_vb", 32'(s_vb), 0);
                chk("s_wrap_vs", 32'(s_vs), 1);
                wrap_pend = 1'b0;
            end
            if (s_h == 11'd23 && s_v == 11'd12) wrap_pend = 1'b1;
            if (c <= 312) begin
                if (s_vb) vb_cnt++;
                if (!s_vs) vs_cnt++;
            end
            if (s_tick) begin
                ticks++;
                chk("tick_h", 32'(s_h), 0);
                chk("tick_v", 32'(s_v), 8);
                chk("tick_fc", 32'(s_fc), 32'(ticks));
                if (last_tick < 0)
                    chk("tick_first", 32'(c), 192);
                else
                    chk("tick_gap", 32'(c - last_tick), 312);
                last_tick = c;
            end
            step(1);
        end
        chk("vb_cycles", 32'(vb_cnt), 120);
        chk("vs_cycles", 32'(vs_cnt), 48);
        chk("tick_count", 32'(ticks), 3);
        chk("fc_final", 32'(s_fc), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
